// File: rtl/pool1_reader.sv
// 3x3 stride-2 per-lane signed max pooling over an IN_DIM x IN_DIM map read tap by tap.
// Define POOL1_RELU_EN to clamp negative pooled lanes to zero.
module pool1_reader #(
    parameter int unsigned IN_DIM  = 111,
    parameter int unsigned OUT_DIM = 55,
    parameter int unsigned CH      = 64,
    parameter int unsigned DW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rden,
    output logic [31:0]      address2,
    input  logic [CH*DW-1:0] datain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH*DW-1:0] out_data,
    output logic [31:0]      out_addr
);

    localparam logic [31:0] InDim   = 32'(IN_DIM);
    localparam logic [31:0] OutLast = 32'(OUT_DIM - 1);
    localparam logic [31:0] LastPix = 32'(OUT_DIM * OUT_DIM - 1);
    // Jump from the last window of a row to the first window two input rows down.
    localparam logic [31:0] WinRowStep = 32'(2 * IN_DIM) - 32'(2 * (OUT_DIM - 1));

    typedef enum logic [1:0] {StIdle, StRead, StOut, StDone} state_e;

    state_e           state_q;
    logic [1:0]       kx_q, ky_q;
    logic [31:0]      ox_q;
    logic [31:0]      pix_q;
    logic [31:0]      win_base_q;
    logic [31:0]      addr_q;
    logic             rden_q, busy_q, done_q, out_valid_q;
    logic [CH*DW-1:0] max_q, max_d;
    logic [CH*DW-1:0] out_data_q, out_d;
    logic [31:0]      out_addr_q;

    logic        first_tap, last_tap, row_end;
    logic [31:0] win_next;

    assign first_tap = (kx_q == 2'd0) && (ky_q == 2'd0);
    assign last_tap  = (kx_q == 2'd2) && (ky_q == 2'd2);
    assign row_end   = (ox_q == OutLast);
    assign win_next  = row_end ? win_base_q + WinRowStep : win_base_q + 32'd2;

    always_comb begin
        max_d = max_q;
        out_d = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (first_tap ||
                ($signed(datain[i*DW +: DW]) > $signed(max_q[i*DW +: DW]))) begin
                max_d[i*DW +: DW] = datain[i*DW +: DW];
            end
`ifdef POOL1_RELU_EN
            out_d[i*DW +: DW] = max_d[i*DW + DW - 1] ? '0 : max_d[i*DW +: DW];
`else
            out_d[i*DW +: DW] = max_d[i*DW +: DW];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            kx_q        <= 2'd0;
            ky_q        <= 2'd0;
            ox_q        <= '0;
            pix_q       <= '0;
            win_base_q  <= '0;
            addr_q      <= '0;
            rden_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            max_q       <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StRead;
                        busy_q     <= 1'b1;
                        rden_q     <= 1'b1;
                        addr_q     <= '0;
                        win_base_q <= '0;
                        kx_q       <= 2'd0;
                        ky_q       <= 2'd0;
                        ox_q       <= '0;
                        pix_q      <= '0;
                    end
                end
                StRead: begin
                    max_q <= max_d;
                    if (last_tap) begin
                        state_q     <= StOut;
                        rden_q      <= 1'b0;
                        addr_q      <= '0;
                        kx_q        <= 2'd0;
                        ky_q        <= 2'd0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= out_d;
                        out_addr_q  <= pix_q;
                    end else if (kx_q == 2'd2) begin
                        kx_q   <= 2'd0;
                        ky_q   <= ky_q + 2'd1;
                        addr_q <= addr_q + InDim - 32'd2;
                    end else begin
                        kx_q   <= kx_q + 2'd1;
                        addr_q <= addr_q + 32'd1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (pix_q == LastPix) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= StRead;
                            rden_q     <= 1'b1;
                            pix_q      <= pix_q + 32'd1;
                            ox_q       <= row_end ? '0 : ox_q + 32'd1;
                            win_base_q <= win_next;
                            addr_q     <= win_next;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rden      = rden_q;
    assign address2  = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_pool1_reader.sv
// Directed bench for pool1_reader with a combinational bank whose lanes derive from the address.
module tb_pool1_reader;

    localparam int CH = 64;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst, start, out_ready;
    logic             busy, done, rden, out_valid;
    logic [31:0]      address2, out_addr;
    logic [CH*DW-1:0] datain, out_data;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    pool1_reader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rden     (rden),
        .address2 (address2),
        .datain   (datain),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_addr (out_addr)
    );

    // lane0: address mod 2^15; lane1: address ^ 0x5A5A; lane2: odd addresses made negative;
    // lane3: -(5 + address mod 7), always negative.
    always_comb begin
        datain = '0;
        datain[0*DW +: DW] = {1'b0, address2[14:0]};
        datain[1*DW +: DW] = address2[15:0] ^ 16'h5A5A;
        datain[2*DW +: DW] = address2[0] ? (16'h8000 | address2[15:0]) : address2[15:0];
        datain[3*DW +: DW] = 16'(32'd0 - (32'd5 + address2 % 32'd7));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane(input int i);
        return 32'(out_data[i*DW +: DW]);
    endfunction

    int          taps [9] = '{0, 1, 2, 111, 112, 113, 222, 223, 224};
    logic [31:0] relu_exp;
    int          hs, done_cnt, done_at, oy, ox;
    logic [31:0] last_addr;

    initial begin
`ifdef POOL1_RELU_EN
        relu_exp = 32'h0000;
`else
        relu_exp = 32'hFFFB;
`endif
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rden", 32'(rden), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr2", address2, 0);
        check("rst_odata", 32'(|out_data), 0);
        check("rst_oaddr", out_addr, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // First window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("w0_rden", 32'(rden), 1);
            check("w0_addr2", address2, 32'(taps[i]));
            check("w0_busy", 32'(busy), 1);
            tick();
        end
        check("w0_valid", 32'(out_valid), 1);
        check("w0_rden_out", 32'(rden), 0);
        check("w0_addr2_out", address2, 0);
        check("w0_oaddr", out_addr, 0);
        check("w0_lane0", lane(0), 224);
        check("w0_lane1", lane(1), 32'h5ABA);
        check("w0_lane2_signed", lane(2), 224);
        check("w0_lane3_neg", lane(3), relu_exp);

        // Back-pressure
        repeat (5) begin
            tick();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_rden", 32'(rden), 0);
            check("stall_lane0", lane(0), 224);
            check("stall_oaddr", out_addr, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("w1_rden", 32'(rden), 1);
            check("w1_addr2", address2, 32'(taps[i] + 2));
            tick();
        end
        check("w1_valid", 32'(out_valid), 1);
        check("w1_oaddr", out_addr, 1);
        check("w1_lane0", lane(0), 226);

        // Full pass
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        hs = 0;
        done_cnt = 0;
        done_at = 0;
        last_addr = '0;
        for (int n = 2; n <= 31000; n++) begin
            tick();
            if (out_valid) begin
                oy = hs / 55;
                ox = hs % 55;
                check("pass_oaddr", out_addr, 32'(hs));
                check("pass_lane0", lane(0), 32'((2 * oy + 2) * 111 + 2 * ox + 2));
                last_addr = out_addr;
                hs++;
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
                check("pass_busy_at_done", 32'(busy), 1);
            end
            if (done_at != 0 && n > done_at + 2) break;
        end
        check("pass_handshakes", 32'(hs), 3025);
        check("pass_last_oaddr", last_addr, 3024);
        check("pass_done_count", 32'(done_cnt), 1);
        check("pass_done_cycle", 32'(done_at), 30251);
        check("pass_busy_after", 32'(busy), 0);

        // Reset in the middle of window 100 (oy=1, ox=45, base 312)
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (1002) tick();
        check("w100_addr2_tap2", address2, 314);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("w100_start_ignored", address2, 423);
        check("w100_rden", 32'(rden), 1);
        check("w100_oaddr_prev", out_addr, 99);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_rden", 32'(rden), 0);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_addr2", address2, 0);
        check("mid_rst_odata", 32'(|out_data), 0);
        check("mid_rst_oaddr", out_addr, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("no_resume_busy", 32'(busy), 0);
        check("no_resume_rden", 32'(rden), 0);
        check("no_resume_valid", 32'(out_valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_rden", 32'(rden), 1);
        check("restart_addr2", address2, 0);
        check("restart_busy", 32'(busy), 1);
        tick();
        check("restart_addr2_tap1", address2, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pool1_reader.md
POOL1_READER -- requirements
Module: pool1_reader

Interface
REQ-001 SHALL have parameter IN_DIM, default 111, input feature-map side length.
REQ-002 SHALL have parameter OUT_DIM, default 55, output side length, equal to (IN_DIM-3)/2+1.
REQ-003 SHALL have parameter CH, default 64, lane (channel) count.
REQ-004 SHALL have parameter DW, default 16, lane width in bits, signed two's complement.
REQ-005 SHALL have port clk, input, 1 bit; the only clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit; one-cycle request to pool the whole map.
REQ-008 SHALL have port busy, output, 1 bit; high from start acceptance until the done cycle, inclusive.
REQ-009 SHALL have port done, output, 1 bit; one-cycle pulse after the last window is accepted.
REQ-010 SHALL have port rden, output, 1 bit; read enable to the conv1 bank store.
REQ-011 SHALL have port address2, output, 32 bits; read address to the bank store.
REQ-012 SHALL have port datain, input, CH*DW bits; bank read data, combinational, valid in the same cycle as address2; lane i is bits [i*DW +: DW].
REQ-013 SHALL have port out_valid, output, 1 bit; pooled vector available.
REQ-014 SHALL have port out_ready, input, 1 bit; consumer accepts when out_valid and out_ready are both high.
REQ-015 SHALL have port out_data, output, CH*DW bits; pooled vector, same lane packing as datain.
REQ-016 SHALL have port out_addr, output, 32 bits; output pixel index oy*OUT_DIM+ox.

Function
REQ-017 SHALL implement states IDLE, READ, OUT and DONE.
REQ-018 SHALL leave IDLE for READ only on start=1, with oy=ox=0 and ky=kx=0.
REQ-019 SHALL, in READ, assert rden=1 with address2=(2*oy+ky)*IN_DIM+(2*ox+kx), stepping kx 0..2 and then ky 0..2, one tap per cycle, 9 cycles per window.
REQ-020 SHALL, per lane, load the tap at ky=kx=0 into the running max.
REQ-021 SHALL, per lane, replace the running max with any later tap that is greater as a signed DW-bit value.
REQ-022 SHALL enter OUT the cycle after the 9th tap, with out_valid=1 and out_data/out_addr registered and held stable until accepted.
REQ-023 SHALL, on acceptance, advance ox; at ox=OUT_DIM-1 it wraps ox to 0 and increments oy, then returns to READ.
REQ-024 SHALL, on acceptance of the window at oy=ox=OUT_DIM-1, go to DONE.
REQ-025 SHALL, in DONE, assert done=1 and busy=1 for one cycle, then return to IDLE.
REQ-026 SHALL drive rden=0 in IDLE, OUT and DONE.
REQ-027 SHALL drive address2 low outside READ.
REQ-028 SHALL ignore start while not in IDLE.
REQ-029 SHALL give a minimum window period of 10 cycles (9 READ + 1 OUT with out_ready=1).
REQ-030 SHALL keep out_valid high, with no data change, while out_ready=0.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-operation, enter IDLE immediately.
REQ-032 SHALL, on rst=1, clear all counters and running maxima.
REQ-033 SHALL, on rst=1, drive busy, done, rden, out_valid, address2, out_data and out_addr to 0.
REQ-034 SHALL not resume an interrupted pass after reset; a new start is required.

Configuration
REQ-035 SHALL, with macro POOL1_RELU_EN defined, clamp each negative lane of out_data to 0 at registration.
REQ-036 SHALL, without POOL1_RELU_EN, pass signed maxima unmodified.

Verification
REQ-037 SHALL cover: bank lane0 = address value (mod 2^15), start pulse -> first window reads addresses 0,1,2,111,112,113,222,223,224; out_data lane0=224; out_addr=0.
REQ-038 SHALL cover: window (oy=0,ox=1) -> reads start at address 2; out_addr=1.
REQ-039 SHALL cover: out_ready held low 5 cycles -> out_valid stays 1, out_data unchanged, no rden.
REQ-040 SHALL cover: lane3 taps all negative, max -5 -> out_data lane3 = 0 with POOL1_RELU_EN, 0xFFFB without.
REQ-041 SHALL cover: full pass with out_ready=1 -> 3025 handshakes, last out_addr=3024, done pulses once 30250 cycles + 1 after start.
REQ-042 SHALL cover: rst asserted in READ of window 100 -> all outputs 0 same cycle; start pulse ignored mid-pass; a later start restarts at address 0.
